// File: rtl/poly_synth_voice_bank.sv
// poly_synth_voice_bank: NUM_CH square/noise voices with linear decay, mixed around mid-scale and clamped.
module poly_synth_voice_bank #(
  parameter int SAMPLE_RATE = 16384,
  parameter int NUM_CH = 4,
  parameter int ENV_W = 4,
  parameter int OUT_W = 8,
  parameter int DECAY_DIV = 256,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_ena,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [CH_W-1:0]   note_ch,
  input  logic [3:0]        note_code,
  input  logic [ENV_W-1:0]  note_vol,
  output logic [OUT_W-1:0]  sample,
  output logic              sample_valid,
  output logic [NUM_CH-1:0] ch_active
);
  localparam int PH_W = $clog2(SAMPLE_RATE);
  localparam int PRE_W = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
  localparam int SUM_W = ENV_W + 2 + CH_W;
  localparam int OW = (OUT_W > SUM_W ? OUT_W : SUM_W) + 2;
  localparam int MID = 1 << (OUT_W - 1);
  localparam logic signed [OW-1:0] MAXV = OW'((1 << OUT_W) - 1);
  localparam logic [15:0][9:0] HZ = {10'd0, 10'd0, 10'd0, 10'd494, 10'd466, 10'd440, 10'd415, 10'd392,
                                     10'd370, 10'd349, 10'd330, 10'd311, 10'd294, 10'd277, 10'd262, 10'd0};
  function automatic logic [15:0][PH_W-1:0] mk_rom();
    logic [15:0][PH_W-1:0] r;
    for (int k = 0; k < 16; k++) r[k] = PH_W'((64'(HZ[k]) << PH_W) / 64'(SAMPLE_RATE));
    return r;
  endfunction
  localparam logic [15:0][PH_W-1:0] ROM = mk_rom();
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] ld_ch_q, ld_ch_d;
  logic [3:0] ld_code_q, ld_code_d;
  logic [ENV_W-1:0] ld_vol_q, ld_vol_d;
  logic [PH_W-1:0] ld_inc_q, ld_inc_d;
  logic [PH_W-1:0] phase_q [NUM_CH], phase_d [NUM_CH], inc_q [NUM_CH], inc_d [NUM_CH];
  logic [ENV_W-1:0] env_q [NUM_CH], env_d [NUM_CH];
  logic [3:0] code_q [NUM_CH], code_d [NUM_CH];
  logic [NUM_CH-1:0] load_v;
  logic [15:0] lfsr_q, lfsr_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic dec, ena1_q, valid_q;
  logic signed [SUM_W-1:0] sum;
  logic signed [OW-1:0] off;
  logic [OUT_W-1:0] sample_q, sample_d;
  assign note_ready = state_q == IDLE;
  assign sample = sample_q;
  assign sample_valid = valid_q;
  always_comb begin
    state_d = state_q == LOAD ? IDLE : note_valid ? LOAD : IDLE;
    ld_ch_d = note_ready && note_valid ? note_ch : ld_ch_q;
    ld_code_d = note_ready && note_valid ? note_code : ld_code_q;
    ld_vol_d = note_ready && note_valid ? note_vol : ld_vol_q;
    ld_inc_d = note_ready && note_valid ? ROM[note_code] : ld_inc_q;
  end
  always_comb begin
    dec = sample_ena && pre_q == PRE_W'(DECAY_DIV - 1);
    pre_d = sample_ena ? (dec ? '0 : pre_q + 1'b1) : pre_q;
    lfsr_d = sample_ena ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
    load_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // A load wins over a coincident sample advance/decay on its own voice only.
      load_v[i] = state_q == LOAD && ld_ch_q == CH_W'(i);
      phase_d[i] = load_v[i] ? '0 : sample_ena ? phase_q[i] + inc_q[i] : phase_q[i];
      env_d[i] = load_v[i] ? ld_vol_q : (dec && env_q[i] != '0) ? env_q[i] - 1'b1 : env_q[i];
      code_d[i] = load_v[i] ? ld_code_q : code_q[i];
      inc_d[i] = load_v[i] ? ld_inc_q : inc_q[i];
    end
  end
  always_comb begin
    ch_active = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_active[i] = code_q[i] != 4'd0 && code_q[i] != 4'd13 && code_q[i] != 4'd14 && env_q[i] != '0;
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++)
      sum = !ch_active[i] ? sum : (code_q[i] == 4'd15 ? lfsr_q[0] : phase_q[i][PH_W-1]) ?
            sum + SUM_W'(env_q[i]) : sum - SUM_W'(env_q[i]);
    off = OW'(sum) + OW'(MID);
    sample_d = off < 0 ? '0 : off > MAXV ? '1 : OUT_W'(off);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ld_ch_q <= '0;
      ld_code_q <= '0;
      ld_vol_q <= '0;
      ld_inc_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
        env_q[i] <= '0;
        code_q[i] <= '0;
        inc_q[i] <= '0;
      end
      lfsr_q <= 16'h0001;
      pre_q <= '0;
      ena1_q <= 1'b0;
      valid_q <= 1'b0;
      sample_q <= OUT_W'(MID);
    end else begin
      state_q <= state_d;
      ld_ch_q <= ld_ch_d;
      ld_code_q <= ld_code_d;
      ld_vol_q <= ld_vol_d;
      ld_inc_q <= ld_inc_d;
      phase_q <= phase_d;
      env_q <= env_d;
      code_q <= code_d;
      inc_q <= inc_d;
      lfsr_q <= lfsr_d;
      pre_q <= pre_d;
      ena1_q <= sample_ena;
      valid_q <= ena1_q;
      sample_q <= ena1_q ? sample_d : sample_q;
    end
  end
endmodule

// File: tb/tb_poly_synth_voice_bank.sv
// tb_poly_synth_voice_bank: directed checks of loading, mixing, clamping, decay, collisions and noise.
module tb_poly_synth_voice_bank;
  logic clock = 1'b0, reset = 1'b1, sample_ena = 1'b0, note_valid = 1'b0;
  logic [1:0] note_ch = '0;
  logic [3:0] note_code = '0, note_vol = '0;
  logic note_ready, sample_valid, note_ready6, sample_valid6;
  logic [7:0] sample;
  logic [5:0] sample6;
  logic [3:0] ch_active, ch_active6;
  int vec = 0, miss = 0, bad, rises;
  logic [7:0] prev;
  logic [15:0] lfsr;
  always #5 clock = ~clock;
  poly_synth_voice_bank u_dut (.clock(clock), .reset(reset), .sample_ena(sample_ena), .note_valid(note_valid),
    .note_ready(note_ready), .note_ch(note_ch), .note_code(note_code), .note_vol(note_vol), .sample(sample),
    .sample_valid(sample_valid), .ch_active(ch_active));
  poly_synth_voice_bank #(.OUT_W(6)) u_dut6 (.clock(clock), .reset(reset), .sample_ena(sample_ena),
    .note_valid(note_valid), .note_ready(note_ready6), .note_ch(note_ch), .note_code(note_code),
    .note_vol(note_vol), .sample(sample6), .sample_valid(sample_valid6), .ch_active(ch_active6));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pulse();
    sample_ena = 1'b1;
    cyc(1);
    sample_ena = 1'b0;
    cyc(1);
  endtask
  task automatic load(input logic [1:0] ch, input logic [3:0] code, input logic [3:0] vol);
    note_valid = 1'b1;
    note_ch = ch;
    note_code = code;
    note_vol = vol;
    cyc(1);
    note_valid = 1'b0;
    cyc(1);
  endtask
  task automatic rst();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask
  initial begin
    cyc(5);
    chk("reset sample", sample, 128);
    chk("reset sample6", sample6, 32);
    chk("reset valid", sample_valid, 0);
    chk("reset ready", note_ready, 1);
    chk("reset active", ch_active, 0);
    reset = 1'b0;
    repeat (3) pulse();
    chk("idle sample", sample, 128);
    chk("idle valid", sample_valid, 1);
    // single A4 square at full volume
    rst();
    load(0, 10, 15);
    chk("a4 active", ch_active, 4'b0001);
    bad = 0;
    rises = 0;
    prev = 8'd113;
    for (int k = 1; k <= 200; k++) begin
      pulse();
      if (sample != 8'd143 && sample != 8'd113) bad++;
      if (prev == 8'd113 && sample == 8'd143) rises++;
      prev = sample;
      if (k == 1) chk("a4 first", sample, 113);
      if (k == 18) chk("a4 k18", sample, 113);
      if (k == 19) chk("a4 k19", sample, 143);
    end
    chk("a4 levels", bad, 0);
    chk("a4 rises", rises, 5);
    cyc(1);
    chk("valid one cycle", sample_valid, 0);
    // four voices in phase, plus clamping on the 6-bit instance
    rst();
    for (int c = 0; c < 4; c++) load(2'(c), 1, 15);
    chk("quad active", ch_active, 4'hF);
    for (int k = 1; k <= 40; k++) begin
      pulse();
      if (k == 1) chk("quad low", sample, 68);
      if (k == 1) chk("quad6 low clamp", sample6, 0);
      if (k == 31) chk("quad k31", sample, 68);
      if (k == 32) chk("quad high", sample, 188);
      if (k == 32) chk("quad6 high clamp", sample6, 63);
    end
    // decay of a vol-3 voice
    rst();
    load(2, 5, 3);
    chk("decay active", ch_active, 4'b0100);
    for (int k = 1; k <= 1024; k++) begin
      pulse();
      if (k == 255) chk("decay k255", sample, 125);
      if (k == 256) chk("decay k256", sample, 126);
      if (k == 767) chk("decay k767 active", ch_active, 4'b0100);
      if (k == 768) chk("decay k768 active", ch_active, 0);
      if (k == 768) chk("decay k768 sample", sample, 128);
    end
    chk("decay no underflow", ch_active, 0);
    chk("decay silent", sample, 128);
    // sustained note_valid: accepts only every other cycle
    rst();
    note_valid = 1'b1;
    note_ch = 0;
    note_code = 1;
    note_vol = 5;
    chk("hold c0 ready", note_ready, 1);
    cyc(1);
    chk("hold c1 ready", note_ready, 0);
    note_ch = 1;
    note_code = 2;
    note_vol = 6;
    cyc(1);
    chk("hold c2 ready", note_ready, 1);
    note_ch = 2;
    note_code = 3;
    note_vol = 7;
    cyc(1);
    chk("hold c3 ready", note_ready, 0);
    note_ch = 3;
    note_code = 4;
    note_vol = 8;
    cyc(1);
    note_valid = 1'b0;
    cyc(1);
    chk("hold active", ch_active, 4'b0101);
    // load coincident with sample_ena restarts the phase at 0
    rst();
    load(0, 10, 15);
    repeat (10) pulse();
    note_valid = 1'b1;
    note_ch = 0;
    note_code = 1;
    note_vol = 9;
    cyc(1);
    note_valid = 1'b0;
    sample_ena = 1'b1;
    cyc(1);
    sample_ena = 1'b0;
    cyc(1);
    chk("collide sample", sample, 119);
    chk("collide valid", sample_valid, 1);
    for (int k = 1; k <= 32; k++) begin
      pulse();
      if (k == 31) chk("collide k31", sample, 119);
      if (k == 32) chk("collide k32", sample, 137);
    end
    // noise voice follows the Galois LFSR
    rst();
    load(0, 15, 8);
    chk("noise active", ch_active, 4'b0001);
    lfsr = 16'h0001;
    for (int k = 1; k <= 40; k++) begin
      pulse();
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      chk("noise sign", sample, lfsr[0] ? 136 : 120);
    end
    // reset while a note is pending in LOAD
    rst();
    note_valid = 1'b1;
    note_ch = 1;
    note_code = 1;
    note_vol = 5;
    cyc(1);
    note_valid = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rst load ready", note_ready, 1);
    cyc(2);
    chk("rst load active", ch_active, 0);
    chk("rst load ready later", note_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
